// File: rtl/bram_bank_arbiter.sv
// rtl/bram_bank_arbiter.sv - per-bank host/engine BRAM arbiter with starvation guard and tagged read return
module bram_bank_arbiter #(
    parameter int BANKS        = 4,
    parameter int DATA_WIDTH   = 16,
    parameter int BANK_ADDR    = 8,
    parameter int WE_BITS      = DATA_WIDTH / 8,
    parameter int RD_LATENCY   = 1,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                          clk,
    input  logic                          resetn,

    input  logic [BANKS-1:0]              h_req,
    input  logic [BANKS*WE_BITS-1:0]      h_we,
    input  logic [BANKS*BANK_ADDR-1:0]    h_addr,
    input  logic [BANKS*DATA_WIDTH-1:0]   h_wrdata,
    output logic [BANKS-1:0]              h_gnt,
    output logic [BANKS-1:0]              h_rvalid,
    output logic [BANKS*DATA_WIDTH-1:0]   h_rddata,

    input  logic [BANKS-1:0]              e_req,
    input  logic [BANKS*WE_BITS-1:0]      e_we,
    input  logic [BANKS*BANK_ADDR-1:0]    e_addr,
    input  logic [BANKS*DATA_WIDTH-1:0]   e_wrdata,
    output logic [BANKS-1:0]              e_gnt,
    output logic [BANKS-1:0]              e_rvalid,
    output logic [BANKS*DATA_WIDTH-1:0]   e_rddata,

    output logic [BANKS-1:0]              bram_en,
    output logic [BANKS*WE_BITS-1:0]      bram_we,
    output logic [BANKS*BANK_ADDR-1:0]    bram_addr,
    output logic [BANKS*DATA_WIDTH-1:0]   bram_wrdata,
    input  logic [BANKS*DATA_WIDTH-1:0]   bram_rddata
);

    localparam int               CNT_W   = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

    logic [BANKS-1:0][CNT_W-1:0]      starve_cnt_q, starve_cnt_d;
    logic [BANKS-1:0][RD_LATENCY-1:0] rd_vld_q, rd_vld_d;
    logic [BANKS-1:0][RD_LATENCY-1:0] rd_own_q, rd_own_d;
    logic [BANKS-1:0]                 force_grant;
    logic [BANKS-1:0]                 rd_push;

    // Host wins by default; a saturated starve counter hands the slot to a waiting engine.
    always_comb begin
        force_grant = '0;
        h_gnt       = '0;
        e_gnt       = '0;
        for (int b = 0; b < BANKS; b++) begin
            force_grant[b] = (starve_cnt_q[b] == CNT_MAX);
            h_gnt[b]       = resetn & h_req[b] & ~(force_grant[b] & e_req[b]);
            e_gnt[b]       = resetn & e_req[b] & (~h_req[b] | force_grant[b]);
        end
    end

    always_comb begin
        bram_en     = h_gnt | e_gnt;
        bram_we     = '0;
        bram_addr   = '0;
        bram_wrdata = '0;
        rd_push     = '0;
        for (int b = 0; b < BANKS; b++) begin
            if (h_gnt[b]) begin
                bram_we[b*WE_BITS +: WE_BITS]          = h_we[b*WE_BITS +: WE_BITS];
                bram_addr[b*BANK_ADDR +: BANK_ADDR]    = h_addr[b*BANK_ADDR +: BANK_ADDR];
                bram_wrdata[b*DATA_WIDTH +: DATA_WIDTH] = h_wrdata[b*DATA_WIDTH +: DATA_WIDTH];
            end else if (e_gnt[b]) begin
                bram_we[b*WE_BITS +: WE_BITS]          = e_we[b*WE_BITS +: WE_BITS];
                bram_addr[b*BANK_ADDR +: BANK_ADDR]    = e_addr[b*BANK_ADDR +: BANK_ADDR];
                bram_wrdata[b*DATA_WIDTH +: DATA_WIDTH] = e_wrdata[b*DATA_WIDTH +: DATA_WIDTH];
            end
            rd_push[b] = bram_en[b] & ~(|bram_we[b*WE_BITS +: WE_BITS]);
        end
    end

    // Return pipe: stage 0 is loaded at the grant edge, the last stage drives rvalid.
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        rd_vld_d     = rd_vld_q;
        rd_own_d     = rd_own_q;
        for (int b = 0; b < BANKS; b++) begin
            if (e_req[b] & ~e_gnt[b]) begin
                starve_cnt_d[b] = (starve_cnt_q[b] == CNT_MAX) ? CNT_MAX
                                                               : starve_cnt_q[b] + CNT_W'(1);
            end else begin
                starve_cnt_d[b] = '0;
            end
            rd_vld_d[b][0] = rd_push[b];
            rd_own_d[b][0] = rd_push[b] & e_gnt[b];
            for (int s = 1; s < RD_LATENCY; s++) begin
                rd_vld_d[b][s] = rd_vld_q[b][s-1];
                rd_own_d[b][s] = rd_own_q[b][s-1];
            end
        end
    end

    always_comb begin
        h_rvalid = '0;
        e_rvalid = '0;
        for (int b = 0; b < BANKS; b++) begin
            h_rvalid[b] = rd_vld_q[b][RD_LATENCY-1] & ~rd_own_q[b][RD_LATENCY-1];
            e_rvalid[b] = rd_vld_q[b][RD_LATENCY-1] &  rd_own_q[b][RD_LATENCY-1];
        end
    end

    assign h_rddata = bram_rddata;
    assign e_rddata = bram_rddata;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            starve_cnt_q <= '0;
            rd_vld_q     <= '0;
            rd_own_q     <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
            rd_vld_q     <= rd_vld_d;
            rd_own_q     <= rd_own_d;
        end
    end

endmodule

// File: tb/tb_bram_bank_arbiter.sv
// tb/tb_bram_bank_arbiter.sv - self-checking bench for bram_bank_arbiter (RD_LATENCY 1 and 2)
module tb_bram_bank_arbiter;

    localparam int SL = 4;

    logic        clk = 1'b0;
    logic        resetn;
    logic [3:0]  h_req, e_req;
    logic [7:0]  h_we, e_we;
    logic [31:0] h_addr, e_addr;
    logic [63:0] h_wrdata, e_wrdata;

    logic [3:0]  h_gnt, h_rvalid, e_gnt, e_rvalid, bram_en;
    logic [63:0] h_rddata, e_rddata, bram_wrdata, bram_rddata;
    logic [7:0]  bram_we;
    logic [31:0] bram_addr;

    logic [3:0]  h_gnt_2, h_rvalid_2, e_gnt_2, e_rvalid_2, bram_en_2;
    logic [63:0] h_rddata_2, e_rddata_2, bram_wrdata_2, bram_rddata_2;
    logic [7:0]  bram_we_2;
    logic [31:0] bram_addr_2;

    bram_bank_arbiter #(.BANKS(4), .DATA_WIDTH(16), .BANK_ADDR(8), .WE_BITS(2),
                        .RD_LATENCY(1), .STARVE_LIMIT(SL)) u_dut (
        .clk(clk), .resetn(resetn),
        .h_req(h_req), .h_we(h_we), .h_addr(h_addr), .h_wrdata(h_wrdata),
        .h_gnt(h_gnt), .h_rvalid(h_rvalid), .h_rddata(h_rddata),
        .e_req(e_req), .e_we(e_we), .e_addr(e_addr), .e_wrdata(e_wrdata),
        .e_gnt(e_gnt), .e_rvalid(e_rvalid), .e_rddata(e_rddata),
        .bram_en(bram_en), .bram_we(bram_we), .bram_addr(bram_addr),
        .bram_wrdata(bram_wrdata), .bram_rddata(bram_rddata)
    );

    bram_bank_arbiter #(.BANKS(4), .DATA_WIDTH(16), .BANK_ADDR(8), .WE_BITS(2),
                        .RD_LATENCY(2), .STARVE_LIMIT(SL)) u_dut2 (
        .clk(clk), .resetn(resetn),
        .h_req(h_req), .h_we(h_we), .h_addr(h_addr), .h_wrdata(h_wrdata),
        .h_gnt(h_gnt_2), .h_rvalid(h_rvalid_2), .h_rddata(h_rddata_2),
        .e_req(e_req), .e_we(e_we), .e_addr(e_addr), .e_wrdata(e_wrdata),
        .e_gnt(e_gnt_2), .e_rvalid(e_rvalid_2), .e_rddata(e_rddata_2),
        .bram_en(bram_en_2), .bram_we(bram_we_2), .bram_addr(bram_addr_2),
        .bram_wrdata(bram_wrdata_2), .bram_rddata(bram_rddata_2)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] init_word(input int b, input int a);
        return 16'(b * 4099 + a * 77 + 3);
    endfunction

    // BRAM model: read-first, 1-cycle output for u_dut, 2-cycle output for u_dut2.
    logic [15:0] mem [4][256];
    logic [15:0] rd1 [4];
    logic [15:0] rd2a [4];
    logic [15:0] rd2b [4];
    logic        mem_ready = 1'b0;

    always @(posedge clk) begin
        if (!mem_ready) begin
            for (int b = 0; b < 4; b++)
                for (int a = 0; a < 256; a++)
                    mem[b][a] <= init_word(b, a);
            mem_ready <= 1'b1;
        end else begin
            for (int b = 0; b < 4; b++) begin
                if (bram_en[b]) begin
                    if (bram_we[2*b +: 2] != 2'b00) begin
                        for (int i = 0; i < 2; i++)
                            if (bram_we[2*b+i])
                                mem[b][bram_addr[8*b +: 8]][8*i +: 8] <= bram_wrdata[16*b+8*i +: 8];
                    end else begin
                        rd1[b] <= mem[b][bram_addr[8*b +: 8]];
                    end
                end
                if (bram_en_2[b] && bram_we_2[2*b +: 2] == 2'b00)
                    rd2a[b] <= mem[b][bram_addr_2[8*b +: 8]];
                rd2b[b] <= rd2a[b];
            end
        end
    end

    always_comb begin
        bram_rddata   = '0;
        bram_rddata_2 = '0;
        for (int b = 0; b < 4; b++) begin
            bram_rddata[16*b +: 16]   = rd1[b];
            bram_rddata_2[16*b +: 16] = rd2b[b];
        end
    end

    // Reference model state
    typedef struct {
        int          due;
        int          bank;
        bit          own;
        logic [15:0] data;
    } rd_t;

    rd_t         q1[$];
    rd_t         q2[$];
    int          m_wait [4];
    logic [15:0] ref_mem [4][256];
    logic [3:0]  m_hg, m_eg;
    int          cyc;
    int          n_checks;
    int          n_fail;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_step();
        logic [3:0]  eh, ee, xhv, xev, xhv2, xev2;
        logic [7:0]  xwe;
        logic [31:0] xad;
        logic [63:0] xwd, xd1, xd2;
        logic [1:0]  we;
        logic [7:0]  a;
        bit          starving;
        rd_t         r;
        eh = '0; ee = '0; xwe = '0; xad = '0; xwd = '0;
        xhv = '0; xev = '0; xhv2 = '0; xev2 = '0; xd1 = '0; xd2 = '0;
        for (int b = 0; b < 4; b++) begin
            starving = (m_wait[b] == SL);
            if (resetn) begin
                if (h_req[b] && !(e_req[b] && starving)) eh[b] = 1'b1;
                else if (e_req[b])                       ee[b] = 1'b1;
            end
            if (eh[b]) begin
                xwe[2*b +: 2] = h_we[2*b +: 2]; xad[8*b +: 8] = h_addr[8*b +: 8];
                xwd[16*b +: 16] = h_wrdata[16*b +: 16];
            end else if (ee[b]) begin
                xwe[2*b +: 2] = e_we[2*b +: 2]; xad[8*b +: 8] = e_addr[8*b +: 8];
                xwd[16*b +: 16] = e_wrdata[16*b +: 16];
            end
        end
        for (int i = 0; i < q1.size(); i++) if (q1[i].due == cyc) begin
            if (q1[i].own) xev[q1[i].bank] = 1'b1; else xhv[q1[i].bank] = 1'b1;
            xd1[16*q1[i].bank +: 16] = q1[i].data;
        end
        for (int i = 0; i < q2.size(); i++) if (q2[i].due == cyc) begin
            if (q2[i].own) xev2[q2[i].bank] = 1'b1; else xhv2[q2[i].bank] = 1'b1;
            xd2[16*q2[i].bank +: 16] = q2[i].data;
        end
        if (!resetn) begin xhv = '0; xev = '0; xhv2 = '0; xev2 = '0; end

        chk("h_gnt", h_gnt, eh);            chk("e_gnt", e_gnt, ee);
        chk("h_gnt_l2", h_gnt_2, eh);       chk("e_gnt_l2", e_gnt_2, ee);
        chk("bram_en", bram_en, eh | ee);   chk("bram_we", bram_we, xwe);
        chk("bram_addr", bram_addr, xad);   chk("bram_wrdata", bram_wrdata, xwd);
        chk("h_rvalid", h_rvalid, xhv);     chk("e_rvalid", e_rvalid, xev);
        chk("h_rvalid_l2", h_rvalid_2, xhv2); chk("e_rvalid_l2", e_rvalid_2, xev2);
        for (int b = 0; b < 4; b++) begin
            if (xhv[b])  chk("h_rddata", h_rddata[16*b +: 16], xd1[16*b +: 16]);
            if (xev[b])  chk("e_rddata", e_rddata[16*b +: 16], xd1[16*b +: 16]);
            if (xhv2[b]) chk("h_rddata_l2", h_rddata_2[16*b +: 16], xd2[16*b +: 16]);
            if (xev2[b]) chk("e_rddata_l2", e_rddata_2[16*b +: 16], xd2[16*b +: 16]);
        end

        if (!resetn) begin
            q1.delete(); q2.delete();
            for (int b = 0; b < 4; b++) m_wait[b] = 0;
        end else begin
            for (int b = 0; b < 4; b++) begin
                if (eh[b] || ee[b]) begin
                    we = xwe[2*b +: 2];
                    a  = xad[8*b +: 8];
                    if (we == 2'b00) begin
                        r.bank = b; r.own = ee[b]; r.data = ref_mem[b][a];
                        r.due = cyc + 1; q1.push_back(r);
                        r.due = cyc + 2; q2.push_back(r);
                    end else begin
                        for (int i = 0; i < 2; i++)
                            if (we[i]) ref_mem[b][a][8*i +: 8] = xwd[16*b+8*i +: 8];
                    end
                end
                if (e_req[b] && !ee[b]) m_wait[b] = (m_wait[b] < SL) ? m_wait[b] + 1 : m_wait[b];
                else                    m_wait[b] = 0;
            end
        end
        while (q1.size() > 0 && q1[0].due <= cyc) void'(q1.pop_front());
        while (q2.size() > 0 && q2[0].due <= cyc) void'(q2.pop_front());
        m_hg = eh;
        m_eg = ee;
        cyc++;
    endtask

    task automatic sample();
        @(negedge clk);
        model_step();
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        h_req = '0; e_req = '0; h_we = '0; e_we = '0;
    endtask

    task automatic set_h(input int b, input logic [1:0] we, input logic [7:0] a, input logic [15:0] d);
        h_req[b] = 1'b1; h_we[2*b +: 2] = we; h_addr[8*b +: 8] = a; h_wrdata[16*b +: 16] = d;
    endtask

    task automatic set_e(input int b, input logic [1:0] we, input logic [7:0] a, input logic [15:0] d);
        e_req[b] = 1'b1; e_we[2*b +: 2] = we; e_addr[8*b +: 8] = a; e_wrdata[16*b +: 16] = d;
    endtask

    task automatic idle_cycle();
        idle(); sample(); advance();
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_gnt"}, {h_gnt, e_gnt, h_gnt_2, e_gnt_2}, 0);
        chk({tag, "_rvalid"}, {h_rvalid, e_rvalid, h_rvalid_2, e_rvalid_2}, 0);
        chk({tag, "_en_we"}, {bram_en, bram_we, bram_en_2, bram_we_2}, 0);
        chk({tag, "_addr"}, {bram_addr, bram_addr_2}, 0);
        chk({tag, "_wrdata"}, bram_wrdata | bram_wrdata_2, 0);
    endtask

    task automatic contention(input bit from_reset, input string tag);
        int nh, ne, both;
        nh = 0; ne = 0; both = 0;
        for (int c = 0; c < 12; c++) begin
            idle();
            set_h(0, 2'b11, 8'h40, 16'hA5A5);
            set_e(0, 2'b11, 8'h50, 16'h5A5A);
            if (from_reset && c == 0) resetn = 1'b1;
            sample();
            chk({tag, "_e_gnt0"}, e_gnt[0], (c == 4 || c == 9) ? 1 : 0);
            chk({tag, "_rvalid"}, {h_rvalid, e_rvalid, h_rvalid_2, e_rvalid_2}, 0);
            nh += int'(h_gnt[0]);
            ne += int'(e_gnt[0]);
            both += int'(h_gnt[0] & e_gnt[0]);
            advance();
        end
        chk({tag, "_host_grants"}, nh, 10);
        chk({tag, "_eng_grants"}, ne, 2);
        chk({tag, "_both_grants"}, both, 0);
    endtask

    typedef struct {
        logic [3:0]  hr, er, xhg, xeg, xen;
        logic [31:0] xaddr;
    } vec_t;

    initial begin
        vec_t        vt[6];
        logic [15:0] d;
        logic [7:0]  wa[8];
        int          nbad;

        n_checks = 0; n_fail = 0; cyc = 0;
        m_hg = '0; m_eg = '0;
        for (int b = 0; b < 4; b++) begin
            m_wait[b] = 0;
            for (int a = 0; a < 256; a++) ref_mem[b][a] = init_word(b, a);
        end
        resetn = 1'b0;
        idle(); h_addr = '0; e_addr = '0; h_wrdata = '0; e_wrdata = '0;
        advance(); advance();

        // Reset state with every request high
        h_req = '1; e_req = '1;
        sample(); check_zero("reset"); advance();
        idle(); resetn = 1'b1; sample(); advance();

        // Single-cycle grant/mux vectors
        vt[0] = '{4'b0001, 4'b0000, 4'b0001, 4'b0000, 4'b0001, 32'h0000_0010};
        vt[1] = '{4'b0000, 4'b1000, 4'b0000, 4'b1000, 4'b1000, 32'h2300_0000};
        vt[2] = '{4'b0101, 4'b0011, 4'b0101, 4'b0010, 4'b0111, 32'h0012_2110};
        vt[3] = '{4'b1111, 4'b1111, 4'b1111, 4'b0000, 4'b1111, 32'h1312_1110};
        vt[4] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 32'h0000_0000};
        vt[5] = '{4'b1010, 4'b0101, 4'b1010, 4'b0101, 4'b1111, 32'h1322_1120};
        for (int i = 0; i < 6; i++) begin
            idle();
            h_addr = 32'h1312_1110; e_addr = 32'h2322_2120;
            h_req = vt[i].hr; e_req = vt[i].er;
            sample();
            chk("vec_h_gnt", h_gnt, vt[i].xhg);
            chk("vec_e_gnt", e_gnt, vt[i].xeg);
            chk("vec_bram_en", bram_en, vt[i].xen);
            chk("vec_bram_addr", bram_addr, vt[i].xaddr);
            advance();
            idle_cycle();
        end

        // Host-only read, bank 2, address 0x15
        idle(); set_h(2, 2'b00, 8'h15, 16'h0000);
        d = ref_mem[2][8'h15];
        sample();
        chk("hr_h_gnt", h_gnt, 4'b0100);
        chk("hr_bram_en", bram_en, 4'b0100);
        chk("hr_addr2", bram_addr[23:16], 8'h15);
        advance();
        idle(); sample();
        chk("hr_h_rvalid", h_rvalid, 4'b0100);
        chk("hr_h_rddata2", h_rddata[47:32], d);
        chk("hr_e_rvalid", e_rvalid, 4'b0000);
        advance();
        idle_cycle();

        contention(1'b0, "cont");
        idle_cycle();

        // Disjoint banks: host writes bank 0 while engine reads bank 3
        idle();
        set_h(0, 2'b11, 8'h33, 16'hBEEF);
        set_e(3, 2'b00, 8'h44, 16'h0000);
        d = ref_mem[3][8'h44];
        sample();
        chk("dj_h_gnt", h_gnt, 4'b0001);
        chk("dj_e_gnt", e_gnt, 4'b1000);
        advance();
        idle(); sample();
        chk("dj_e_rvalid", e_rvalid, 4'b1000);
        chk("dj_e_rddata3", e_rddata[63:48], d);
        chk("dj_mem_write", mem[0][8'h33], 16'hBEEF);
        advance();
        idle_cycle();

        // RD_LATENCY=2: three back-to-back engine reads on bank 1
        for (int c = 0; c < 6; c++) begin
            idle();
            if (c < 3) set_e(1, 2'b00, 8'(c), 16'h0000);
            sample();
            chk("l2_e_rvalid1", e_rvalid_2[1], (c >= 2 && c <= 4) ? 1 : 0);
            if (c >= 2 && c <= 4) chk("l2_e_rddata1", e_rddata_2[31:16], ref_mem[1][c-2]);
            chk("l2_h_rvalid", h_rvalid_2, 4'b0000);
            advance();
        end
        idle_cycle();

        // Write-only traffic on bank 1
        for (int i = 0; i < 8; i++) begin
            idle();
            wa[i] = 8'($urandom);
            set_h(1, 2'($urandom_range(1, 3)), wa[i], 16'($urandom));
            sample();
            chk("wo_rvalid", {h_rvalid, e_rvalid, h_rvalid_2, e_rvalid_2}, 0);
            advance();
        end
        idle(); sample();
        chk("wo_rvalid", {h_rvalid, e_rvalid, h_rvalid_2, e_rvalid_2}, 0);
        advance();
        for (int i = 0; i < 8; i++) chk("wo_mem", mem[1][wa[i]], ref_mem[1][wa[i]]);

        // Reset in the cycle after a granted read, with the starve counter part-way up
        idle_cycle();
        for (int c = 0; c < 3; c++) begin
            idle();
            set_h(0, 2'b11, 8'h40, 16'hA5A5);
            set_e(0, 2'b11, 8'h50, 16'h5A5A);
            if (c == 2) set_h(2, 2'b00, 8'h07, 16'h0000);
            sample();
            advance();
        end
        resetn = 1'b0;
        sample(); check_zero("midrst"); advance();
        sample(); check_zero("midrst_hold"); advance();
        contention(1'b1, "post_rst");
        idle_cycle();

        // Randomized traffic with the hold-until-granted rule
        for (int c = 0; c < 400; c++) begin
            for (int b = 0; b < 4; b++) begin
                if (!(h_req[b] && !m_hg[b])) begin
                    if ($urandom_range(0, 99) < 55)
                        set_h(b, $urandom_range(0, 1) ? 2'b00 : 2'($urandom_range(1, 3)),
                              8'($urandom_range(0, 15)), 16'($urandom));
                    else h_req[b] = 1'b0;
                end
                if (!(e_req[b] && !m_eg[b])) begin
                    if ($urandom_range(0, 99) < 70)
                        set_e(b, $urandom_range(0, 1) ? 2'b00 : 2'($urandom_range(1, 3)),
                              8'($urandom_range(0, 15)), 16'($urandom));
                    else e_req[b] = 1'b0;
                end
            end
            sample();
            advance();
        end
        idle_cycle();
        idle_cycle();

        nbad = 0;
        for (int b = 0; b < 4; b++)
            for (int a = 0; a < 256; a++)
                if (mem[b][a] !== ref_mem[b][a]) nbad++;
        chk("mem_image_bad_words", nbad, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
